// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and the
// sequential address step.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding on the instruction memory port
    STALL = 2'd1,  // fetched word parked in the buffer while decode is frozen
    DRAIN = 2'd2   // redirect pending, waiting for the in-flight read to finish
  } state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  // Sequential address step; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] addr);
    return addr + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one read at a time to instruction memory,
// registers the returned word for decode, buffers one word across a decode
// freeze and handles branch redirects, including those that arrive while a
// read is still in flight.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        valid_out
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_word;
  logic [31:0] target;
  logic        consume;

  // Decode takes the presented instruction whenever it is valid and not held.
  assign consume = valid_out & ~freeze;

  // A read is outstanding in every state except STALL; reset kills it at once
  // so nothing is requested (and no ack is honoured) while rst is high.
  assign imem_req  = ~rst & (state != STALL);
  assign imem_addr = pc;

  // Fetch FSM and output registers; a redirect always beats freeze and ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      buf_word    <= 32'h0;
      target      <= 32'h0;
      Instruction <= 32'h0;
      PC          <= 32'h0;
      valid_out   <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (branch_taken) begin
            valid_out <= 1'b0;
            if (imem_ack) begin
              // The returned word belongs to the wrong path; drop it.
              pc <= branch_addr;
            end else begin
              // The read cannot be abandoned, so remember where to go next.
              target <= branch_addr;
              state  <= DRAIN;
            end
          end else if (imem_ack && !(valid_out && freeze)) begin
            Instruction <= imem_rdata;
            PC          <= pc_plus4(pc);
            valid_out   <= 1'b1;
            pc          <= pc_plus4(pc);
          end else if (imem_ack) begin
            // Output register still occupied: park the word, stop fetching.
            buf_word <= imem_rdata;
            state    <= STALL;
          end else if (consume) begin
            valid_out <= 1'b0;
          end
        end

        STALL: begin
          if (branch_taken) begin
            valid_out <= 1'b0;
            pc        <= branch_addr;
            state     <= FETCH;
          end else if (!freeze) begin
            Instruction <= buf_word;
            PC          <= pc_plus4(pc);
            valid_out   <= 1'b1;
            pc          <= pc_plus4(pc);
            state       <= FETCH;
          end
        end

        DRAIN: begin
          if (branch_taken) begin
            // Newest redirect wins over any earlier pending target.
            valid_out <= 1'b0;
            if (imem_ack) begin
              pc    <= branch_addr;
              state <= FETCH;
            end else begin
              target <= branch_addr;
            end
          end else begin
            if (consume) begin
              valid_out <= 1'b0;
            end
            if (imem_ack) begin
              pc    <= target;
              state <= FETCH;
            end
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected instruction/PC pairs are queued
// when an accepted read is returned and checked when decode consumes them.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        valid_out;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .PC          (PC),
    .valid_out   (valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Decode takes the current output this cycle: compare it with the oldest entry.
  task automatic consume();
    logic [63:0] e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_underflow observed %0d expected >0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("instr", Instruction, e[63:32]);
      chk("pc_out", PC, e[31:0]);
    end
  endtask

  // One clock: drive inputs away from the edge, then sample at the falling edge.
  task automatic step(input logic ack, input logic [31:0] rd, input logic frz,
                      input logic br, input logic [31:0] ba);
    imem_ack     = ack;
    imem_rdata   = rd;
    freeze       = frz;
    branch_taken = br;
    branch_addr  = ba;
    if (valid_out && !frz) consume();
    @(negedge clk);
    $display("step ack=%0b frz=%0b br=%0b ba=%h -> req=%0b addr=%h valid=%0b instr=%h pc=%h",
             ack, frz, br, ba, imem_req, imem_addr, valid_out, Instruction, PC);
  endtask

  // Request held one cycle, acked the next; the word must appear one cycle later.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] d);
    chk("req", {31'h0, imem_req}, 32'd1);
    chk("addr", imem_addr, a);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("req_hold", {31'h0, imem_req}, 32'd1);
    chk("addr_hold", imem_addr, a);
    chk("bubble", {31'h0, valid_out}, 32'd0);
    sb.push_back({d, a + 32'd4});
    step(1'b1, d, 1'b0, 1'b0, 32'h0);
    chk("valid_latency", {31'h0, valid_out}, 32'd1);
  endtask

  // Reset pulse with a stray ack during reset; anything queued is abandoned.
  task automatic do_reset();
    sb.delete();
    imem_ack     = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    rst          = 1'b1;
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_valid", {31'h0, valid_out}, 32'd0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_pc_out", PC, 32'h0);
    chk("rst_addr", imem_addr, RST_PC);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("rst_ack_ignored", {31'h0, valid_out}, 32'd0);
    chk("rst_req_low", {31'h0, imem_req}, 32'd0);
    imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req", {31'h0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, RST_PC);
    $display("reset released addr=%h req=%0b", imem_addr, imem_req);
  endtask

  initial begin
    #2;
    do_reset();

    // Sequential fetch from reset: addresses 0, 4, 8 and PC 4, 8, 12.
    fetch_one(32'h0, 32'hA000_0001);
    fetch_one(32'h4, 32'hA000_0002);
    fetch_one(32'h8, 32'hA000_0003);

    // Freeze for three cycles while the next word arrives.
    sb.push_back({32'hA000_0004, 32'd16});
    step(1'b1, 32'hA000_0004, 1'b1, 1'b0, 32'h0);
    chk("stall_req", {31'h0, imem_req}, 32'd0);
    chk("stall_valid", {31'h0, valid_out}, 32'd1);
    chk("stall_instr", Instruction, 32'hA000_0003);
    chk("stall_pc_out", PC, 32'd12);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("stall_hold_instr", Instruction, 32'hA000_0003);
    chk("stall_hold_req", {31'h0, imem_req}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("stall_hold2_req", {31'h0, imem_req}, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("unstall_valid", {31'h0, valid_out}, 32'd1);
    chk("unstall_instr", Instruction, 32'hA000_0004);
    fetch_one(32'd16, 32'hA000_0005);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Branch while the read to 0x8 is outstanding.
    do_reset();
    fetch_one(32'h0, 32'hB000_0001);
    fetch_one(32'h4, 32'hB000_0002);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    chk("drain_valid", {31'h0, valid_out}, 32'd0);
    chk("drain_req", {31'h0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h8);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_addr_hold", imem_addr, 32'h8);
    chk("drain_valid_hold", {31'h0, valid_out}, 32'd0);
    step(1'b1, 32'hDEAD_DEAD, 1'b0, 1'b0, 32'h0);
    chk("drain_drop_valid", {31'h0, valid_out}, 32'd0);
    chk("redirect_addr", imem_addr, 32'h100);
    fetch_one(32'h100, 32'hB000_0003);

    // Branch coinciding with ack in FETCH.
    step(1'b1, 32'hBAD1_BAD1, 1'b0, 1'b1, 32'h180);
    chk("br_ack_valid", {31'h0, valid_out}, 32'd0);
    chk("br_ack_addr", imem_addr, 32'h180);
    fetch_one(32'h180, 32'hB000_0004);

    // Two redirects in DRAIN (first one under freeze, dropping the held word).
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    void'(sb.pop_front());
    chk("br_freeze_valid", {31'h0, valid_out}, 32'd0);
    chk("drain2_addr", imem_addr, 32'h184);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    chk("drain2_addr_hold", imem_addr, 32'h184);
    step(1'b1, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'h0);
    chk("newest_target", imem_addr, 32'h300);
    fetch_one(32'h300, 32'hB000_0005);

    // Reset in the middle of a read at 0x40.
    step(1'b1, 32'hBAD2_BAD2, 1'b0, 1'b1, 32'h40);
    chk("addr_40", imem_addr, 32'h40);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("req_40", {31'h0, imem_req}, 32'd1);
    do_reset();
    fetch_one(32'h0, 32'hC000_0001);

    // Address wrap and unaligned branch target pass-through.
    step(1'b1, 32'hBAD3_BAD3, 1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 32'hC000_0002);
    chk("wrap_addr", imem_addr, 32'h0);
    step(1'b1, 32'hBAD4_BAD4, 1'b0, 1'b1, 32'h203);
    chk("low_bits_addr", imem_addr, 32'h203);
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
